// File: rtl/usb_ep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_pkg
// Description : Shared types and constants for the endpoint loopback backend.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_ep_pkg;

    localparam int USB_FS_MAX_PACKET_SIZE = 64;

    typedef enum logic [2:0] {
        LB_IDLE      = 3'd0,
        LB_POP       = 3'd1,
        LB_POP_DONE  = 3'd2,
        LB_POP_FAIL  = 3'd3,
        LB_FILL      = 3'd4,
        LB_FILL_DONE = 3'd5
    } LoopbackState_t;

endpackage
`default_nettype wire

// File: rtl/usb_ep_loopback_buf.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_loopback_buf
// Description : DEPTH x 8 simple dual-port RAM, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_loopback_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/usb_ep_loopback.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_loopback
// Description : Pops one host->device packet into a local buffer and pushes it
//               back out on the same endpoint, optionally XOR-masked.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_loopback
    import usb_ep_pkg::*;
#(
    parameter int         BUF_DEPTH = USB_FS_MAX_PACKET_SIZE,
    parameter logic [7:0] XOR_MASK  = 8'h00
) (
    input  logic        clk12_i,
    input  logic        rstn_i,
    input  logic        EP_IN_dataAvailable_i,
    input  logic [7:0]  EP_IN_data_i,
    output logic        EP_IN_popData_o,
    output logic        EP_IN_popTransDone_o,
    output logic        EP_IN_popTransSuccess_o,
    input  logic        EP_OUT_full_i,
    output logic        EP_OUT_dataValid_o,
    output logic [7:0]  EP_OUT_data_o,
    output logic        EP_OUT_fillTransDone_o,
    output logic        EP_OUT_fillTransSuccess_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic [15:0] echoCount_o
);

    localparam int               c_AW       = $clog2(BUF_DEPTH);
    localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]    c_LEN_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW:0]    c_LEN_FULL = (c_AW+1)'(BUF_DEPTH);

    LoopbackState_t  r_state;
    LoopbackState_t  w_state_nxt;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_len;
    logic            r_primed;
    logic            r_overflow;
    logic [15:0]     r_echo_count;

    logic            w_wr_en;
    logic            w_accept;
    logic            w_set_ovf;
    logic            w_last;
    logic            w_out_valid;
    logic [c_AW-1:0] w_rd_addr;
    logic [7:0]      w_rd_data;

    assign w_last = (({1'b0, r_rd_ptr} + c_LEN_ONE) == r_len);

    always_comb begin
        w_state_nxt               = r_state;
        w_wr_en                   = 1'b0;
        w_accept                  = 1'b0;
        w_set_ovf                 = 1'b0;
        w_out_valid               = 1'b0;
        EP_IN_popData_o           = 1'b0;
        EP_IN_popTransDone_o      = 1'b0;
        EP_IN_popTransSuccess_o   = 1'b0;
        EP_OUT_fillTransDone_o    = 1'b0;
        EP_OUT_fillTransSuccess_o = 1'b0;
        case (r_state)
            LB_IDLE: begin
                if (EP_IN_dataAvailable_i) begin
                    w_state_nxt = LB_POP;
                end
            end
            LB_POP: begin
                EP_IN_popData_o = EP_IN_dataAvailable_i;
                if (EP_IN_dataAvailable_i) begin
                    // A byte arriving with the buffer already full is consumed but dropped.
                    if (r_len == c_LEN_FULL) begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = LB_POP_FAIL;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end else if (r_len != '0) begin
                    w_state_nxt = LB_POP_DONE;
                end
            end
            LB_POP_DONE: begin
                EP_IN_popTransDone_o    = 1'b1;
                EP_IN_popTransSuccess_o = 1'b1;
                w_state_nxt             = LB_FILL;
            end
            LB_POP_FAIL: begin
                EP_IN_popTransDone_o = 1'b1;
                w_state_nxt          = LB_IDLE;
            end
            LB_FILL: begin
                // First FILL cycle only primes the RAM read register.
                w_out_valid = r_primed;
                w_accept    = r_primed & ~EP_OUT_full_i;
                if (w_accept && w_last) begin
                    w_state_nxt = LB_FILL_DONE;
                end
            end
            LB_FILL_DONE: begin
                EP_OUT_fillTransDone_o    = 1'b1;
                EP_OUT_fillTransSuccess_o = 1'b1;
                w_state_nxt               = LB_IDLE;
            end
            default: begin
                w_state_nxt = LB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= LB_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_len        <= '0;
            r_primed     <= 1'b0;
            r_overflow   <= 1'b0;
            r_echo_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_primed <= (r_state == LB_FILL);
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_len    <= r_len + c_LEN_ONE;
            end
            if (w_accept) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
            if (r_state == LB_POP_FAIL || r_state == LB_FILL_DONE) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_len    <= '0;
            end
            if (r_state == LB_FILL_DONE) begin
                r_echo_count <= r_echo_count + 16'd1;
            end
        end
    end

    // Look ahead on accept so the next byte is already registered when rd_ptr advances.
    assign w_rd_addr = w_accept ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

    usb_ep_loopback_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (c_AW)
    ) u_buf (
        .clk       (clk12_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (EP_IN_data_i),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign EP_OUT_dataValid_o = w_out_valid;
    assign EP_OUT_data_o      = w_out_valid ? (w_rd_data ^ XOR_MASK) : 8'h00;
    assign busy_o             = (r_state != LB_IDLE);
    assign overflow_o         = r_overflow;
    assign echoCount_o        = r_echo_count;

endmodule
`default_nettype wire
